// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX control stage: control bundle, ALU op codes, stall FSM states.
package pipeline_pkg;

  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] SUB    = 2'b01;
  localparam logic [1:0] R_TYPE = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_bundle_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} stall_state_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a valid load in EX whose rd feeds the ID instruction.
module load_use_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  output logic       haz_o
);

  // x0 is never a real producer, so a load to it cannot create a dependency
  assign haz_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                 ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with a counter-based load-use stall FSM.
// Define HAZ_STATS_EN to add the stall_count / flush_count statistics outputs.
module id_ex_ctrl_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic [1:0]  id_alu_op,
  input  logic        id_reg_dst,
  input  logic        id_branch,
  input  logic        id_mem_read,
  input  logic        id_mem_2_reg,
  input  logic        id_mem_write,
  input  logic        id_alu_src,
  input  logic        id_reg_write,
  input  logic        id_jump,
  input  logic        id_flush,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs2,
  output logic [1:0]  ex_alu_op,
  output logic        ex_reg_dst,
  output logic        ex_branch,
  output logic        ex_mem_read,
  output logic        ex_mem_2_reg,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_jump,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
`ifdef HAZ_STATS_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
`endif
  output logic        stall_if_id
);

  localparam logic [1:0] CNT_INIT = 2'(STALL_CYCLES - 1);

  ctrl_bundle_t ctrl_q, ctrl_d, id_ctrl;
  logic [4:0]   rd_q, rd_d;
  logic         vld_q, vld_d;
  stall_state_t state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         haz;

  assign id_ctrl = '{alu_op: id_alu_op, reg_dst: id_reg_dst, branch: id_branch,
                     mem_read: id_mem_read, mem_2_reg: id_mem_2_reg,
                     mem_write: id_mem_write, alu_src: id_alu_src,
                     reg_write: id_reg_write, jump: id_jump};

  load_use_detect u_detect (
    .ex_valid_i    (vld_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs2_i (id_uses_rs2),
    .haz_o         (haz)
  );

  always_comb begin
    ctrl_d      = BUBBLE;
    rd_d        = 5'd0;
    vld_d       = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_id = 1'b0;
    unique case (state_q)
      RUN: begin
        if (haz && !id_flush) begin
          stall_if_id = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = (CNT_INIT != 2'd0) ? STALL : RUN;
        end else if (!id_flush) begin
          ctrl_d = id_ctrl;
          rd_d   = id_rd;
          vld_d  = 1'b1;
        end
      end
      STALL: begin
        if (id_flush) begin
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          stall_if_id = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
      end
    endcase
    if (!arst_n) stall_if_id = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ctrl_q  <= BUBBLE;
      rd_q    <= 5'd0;
      vld_q   <= 1'b0;
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else if (enable) begin
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else if (enable) begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall_if_id};
      flush_cnt_q <= flush_cnt_q + {31'd0, id_flush};
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

  assign ex_alu_op    = ctrl_q.alu_op;
  assign ex_reg_dst   = ctrl_q.reg_dst;
  assign ex_branch    = ctrl_q.branch;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_2_reg = ctrl_q.mem_2_reg;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_alu_src   = ctrl_q.alu_src;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_jump      = ctrl_q.jump;
  assign ex_rd        = rd_q;
  assign ex_valid     = vld_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: three instances (STALL_CYCLES 1..3) share one directed stimulus
// stream and are compared every cycle against a remaining-stall-count reference model.
module tb_id_ex_ctrl_stage;

  // control vector: {alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
  localparam logic [9:0] NOP  = 10'b00_0000_0000;
  localparam logic [9:0] LW   = 10'b00_0011_0110;
  localparam logic [9:0] ADDR = 10'b10_1000_0010;
  localparam logic [9:0] ADDI = 10'b00_0000_0110;

  logic       clk = 1'b0, arst_n = 1'b0, enable = 1'b1;
  logic [9:0] id_c = '0;
  logic       id_flush = 1'b0, id_uses = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic [2:0][9:0]  ex_c;
  logic [2:0][4:0]  ex_rd;
  logic [2:0]       ex_v, stl;
  logic [2:0][31:0] sc_w, fc_w;

  int errors = 0, checks = 0;
  logic chk_en = 1'b0, cnt_on = 1'b0;
  int acc [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [1:0]  alu_op;
    logic        rdst, br, mr, m2r, mw, asrc, rw, jmp, v, s;
    logic [4:0]  rd;
    logic [31:0] sc, fc;
    id_ex_ctrl_stage #(.STALL_CYCLES(g + 1)) dut (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .id_alu_op(id_c[9:8]), .id_reg_dst(id_c[7]), .id_branch(id_c[6]),
      .id_mem_read(id_c[5]), .id_mem_2_reg(id_c[4]), .id_mem_write(id_c[3]),
      .id_alu_src(id_c[2]), .id_reg_write(id_c[1]), .id_jump(id_c[0]),
      .id_flush(id_flush), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs2(id_uses),
      .ex_alu_op(alu_op), .ex_reg_dst(rdst), .ex_branch(br), .ex_mem_read(mr),
      .ex_mem_2_reg(m2r), .ex_mem_write(mw), .ex_alu_src(asrc), .ex_reg_write(rw),
      .ex_jump(jmp), .ex_rd(rd), .ex_valid(v),
`ifdef HAZ_STATS_EN
      .stall_count(sc), .flush_count(fc),
`endif
      .stall_if_id(s)
    );
`ifndef HAZ_STATS_EN
    assign sc = '0;
    assign fc = '0;
`endif
    assign ex_c[g]  = {alu_op, rdst, br, mr, m2r, mw, asrc, rw, jmp};
    assign ex_rd[g] = rd;
    assign ex_v[g]  = v;
    assign stl[g]   = s;
    assign sc_w[g]  = sc;
    assign fc_w[g]  = fc;
  end

  // Reference model: EX contents plus how many more stall cycles are still owed after this one
  logic [2:0][9:0] m_c  = '0;
  logic [2:0][4:0] m_rd = '0;
  logic [2:0]      m_v  = '0;
  int              m_left [3];
  logic [31:0]     m_sc [3], m_fc [3];

  function automatic logic m_haz(int k);
    return m_v[k] && m_c[k][5] && (m_rd[k] != 5'd0) &&
           ((m_rd[k] == id_rs1) || (id_uses && (m_rd[k] == id_rs2)));
  endfunction

  function automatic logic m_stall(int k);
    if (!arst_n) return 1'b0;
    if (m_left[k] > 0) return !id_flush;
    return m_haz(k) && !id_flush;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!arst_n) begin
        m_c[k] = '0; m_rd[k] = '0; m_v[k] = 1'b0; m_left[k] = 0; m_sc[k] = '0; m_fc[k] = '0;
      end else if (enable) begin
        logic st, hz;
        st = m_stall(k);
        hz = m_haz(k);
        if (st) m_sc[k] = m_sc[k] + 1;
        if (id_flush) m_fc[k] = m_fc[k] + 1;
        if (m_left[k] > 0 || (hz && !id_flush) || id_flush) begin
          if (m_left[k] > 0) m_left[k] = id_flush ? 0 : m_left[k] - 1;
          else if (hz && !id_flush) m_left[k] = k;  // STALL_CYCLES-1 more after this cycle
          m_c[k] = '0; m_rd[k] = '0; m_v[k] = 1'b0;
        end else begin
          m_c[k] = id_c; m_rd[k] = id_rd; m_v[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ex_ctrl[%0d]", k), 32'(ex_c[k]), 32'(m_c[k]));
        chk($sformatf("ex_rd[%0d]", k), 32'(ex_rd[k]), 32'(m_rd[k]));
        chk($sformatf("ex_valid[%0d]", k), 32'(ex_v[k]), 32'(m_v[k]));
        chk($sformatf("stall[%0d]", k), 32'(stl[k]), 32'(m_stall(k)));
`ifdef HAZ_STATS_EN
        chk($sformatf("stall_count[%0d]", k), sc_w[k], m_sc[k]);
        chk($sformatf("flush_count[%0d]", k), fc_w[k], m_fc[k]);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (cnt_on) for (int k = 0; k < 3; k++) acc[k] += int'(stl[k]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [9:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic uses, input logic fl);
    id_c = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses = uses; id_flush = fl;
  endtask

  task automatic win_start();
    for (int k = 0; k < 3; k++) acc[k] = 0;
    cnt_on = 1'b1;
  endtask

  task automatic win_check(input string nm, input int e0, input int e1, input int e2);
    int exp [3];
    cnt_on = 1'b0;
    exp = '{e0, e1, e2};
    for (int k = 0; k < 3; k++) chk($sformatf("%s[%0d]", nm, k), 32'(acc[k]), 32'(exp[k]));
  endtask

  initial begin
    // reset with random ID inputs
    arst_n = 1'b0;
    set_id(10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'b0);
    tick();
    chk_en = 1'b1;
    set_id(10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ctrl[%0d]", k), 32'(ex_c[k]), 32'd0);
      chk($sformatf("rst_valid[%0d]", k), 32'(ex_v[k]), 32'd0);
      chk($sformatf("rst_stall[%0d]", k), 32'(stl[k]), 32'd0);
    end
    arst_n = 1'b1;
    set_id(NOP, 0, 0, 0, 0, 0);
    tick();

    // lw x5 ; add x6,x5,x1
    set_id(LW, 1, 0, 5, 0, 0); tick();
    set_id(ADDR, 5, 1, 6, 1, 0);
    win_start(); repeat (5) tick(); win_check("rs1_stall_len", 1, 2, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("add_in_ex_rd[%0d]", k), 32'(ex_rd[k]), 32'd6);
      chk($sformatf("add_in_ex_rw[%0d]", k), 32'(ex_c[k][1]), 32'd1);
    end

    // lw x0 ; add x1,x0,x0
    set_id(NOP, 0, 0, 0, 0, 0); tick();
    set_id(LW, 2, 0, 0, 0, 0); tick();
    set_id(ADDR, 0, 0, 1, 1, 0);
    win_start(); repeat (2) tick(); win_check("x0_no_stall", 0, 0, 0);

    // lw x7 ; I-type with rs2 field 7 but rs2 unused
    set_id(LW, 2, 0, 7, 0, 0); tick();
    set_id(ADDI, 3, 7, 8, 0, 0);
    win_start(); repeat (2) tick(); win_check("rs2_unused_no_stall", 0, 0, 0);

    // load-use with enable low for two cycles mid-window
    set_id(NOP, 0, 0, 0, 0, 0); tick();
    set_id(LW, 1, 0, 5, 0, 0); tick();
    set_id(ADDR, 2, 5, 6, 1, 0);
    win_start();
    tick();
    enable = 1'b0; tick(); tick();
    enable = 1'b1; repeat (4) tick();
    win_check("en_hold_stall_len", 1, 4, 5);

    // flush coinciding with a hazard
    set_id(NOP, 0, 0, 0, 0, 0); tick();
    set_id(LW, 1, 0, 5, 0, 0); tick();
    set_id(ADDR, 5, 1, 6, 1, 1);
    win_start(); tick(); win_check("flush_haz_stall", 0, 0, 0);
    for (int k = 0; k < 3; k++) chk($sformatf("flush_bubble[%0d]", k), 32'(ex_v[k]), 32'd0);
    set_id(ADDR, 5, 1, 6, 1, 0); tick();

    // flush in the 2nd cycle of the stall window
    set_id(NOP, 0, 0, 0, 0, 0); tick();
    set_id(LW, 1, 0, 5, 0, 0); tick();
    set_id(ADDR, 5, 1, 6, 1, 0);
    win_start();
    tick();
    id_flush = 1'b1; tick();
    for (int k = 0; k < 3; k++) chk($sformatf("midflush_bubble[%0d]", k), 32'(ex_v[k]), 32'd0);
    id_flush = 1'b0; tick(); tick();
    win_check("midflush_stall_len", 1, 1, 1);

    // statistics: 4 hazards and 3 flushes from a clean reset
    arst_n = 1'b0; tick();
    arst_n = 1'b1;
    set_id(NOP, 0, 0, 0, 0, 0); tick();
    win_start();
    repeat (4) begin
      set_id(LW, 1, 0, 9, 0, 0); tick();
      set_id(ADDR, 3, 9, 10, 1, 0); repeat (3) tick();
    end
    win_check("four_haz_stalls", 4, 8, 12);
    set_id(NOP, 0, 0, 0, 0, 1); repeat (3) tick();
    id_flush = 1'b0; tick();
`ifdef HAZ_STATS_EN
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stats_stall[%0d]", k), sc_w[k], 32'(4 * (k + 1)));
      chk($sformatf("stats_flush[%0d]", k), fc_w[k], 32'd3);
    end
`endif

    // reset in the middle of a stall window
    set_id(LW, 1, 0, 5, 0, 0); tick();
    set_id(ADDR, 5, 1, 6, 1, 0); tick();
    arst_n = 1'b0; tick();
    for (int k = 0; k < 3; k++) chk($sformatf("midrst_valid[%0d]", k), 32'(ex_v[k]), 32'd0);
    arst_n = 1'b1;
    win_start(); tick(); win_check("midrst_no_stall", 0, 0, 0);
`ifdef HAZ_STATS_EN
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_stall_cnt[%0d]", k), sc_w[k], 32'd0);
      chk($sformatf("midrst_flush_cnt[%0d]", k), fc_w[k], 32'd0);
    end
`endif

    set_id(NOP, 0, 0, 0, 0, 0); tick(); tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
